// File: rtl/id_key_sequencer.sv
// rtl/id_key_sequencer.sv - knock-key unlock sequencer that serially reveals a device ID word
module id_key_sequencer #(
   parameter logic [15:0] KEY         = 16'hA5C3,
   parameter logic [31:0] ID          = 32'h93A5_0038,
   parameter int          TIMEOUT     = 1024,
   parameter int          LOCKOUT_CYC = 4096
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       bus_valid,
   input  logic [9:0] ba,
   input  logic       br_w,
   input  logic       sser,
   output logic       sdrd,
   output logic       sdrd_oe,
   output logic       unlocked,
   output logic       locked_out
);

   localparam int TW = $clog2(TIMEOUT);
   localparam int LW = $clog2(LOCKOUT_CYC);
   localparam logic [TW-1:0] IDLE_MAX = TW'(TIMEOUT - 1);
   localparam logic [LW-1:0] LOCK_MAX = LW'(LOCKOUT_CYC - 1);

   typedef enum logic [2:0] {
      S_LOCKED   = 3'd0,
      S_K1       = 3'd1,
      S_K2       = 3'd2,
      S_K3       = 3'd3,
      S_UNLOCKED = 3'd4,
      S_LOCKOUT  = 3'd5
   } state_t;

   state_t        state, state_nxt;
   logic [1:0]    fail_cnt;
   logic [TW-1:0] idle_cnt;
   logic [LW-1:0] lock_cnt;
   logic [4:0]    bit_cnt;

   logic       sel, hit, wwr;
   logic [3:0] nib, exp_nib;
   logic [1:0] fail_sat;
   logic       fail_trip, active, timed_out;
   logic       fail_ev, key_done, data_hit, abort;

   // ba carries address bits [13:4], so the window field [13:12] is ba[9:8]
   assign sel       = bus_valid & ~sser & (ba[9:8] == 2'b01);
   assign hit       = sel & br_w;
   assign wwr       = sel & ~br_w;
   assign nib       = ba[3:0];
   assign fail_sat  = (fail_cnt == 2'd3) ? 2'd3 : fail_cnt + 2'd1;
   assign fail_trip = (fail_sat == 2'd3);
   assign active    = (state == S_K1) || (state == S_K2) || (state == S_K3) || (state == S_UNLOCKED);
   assign timed_out = (idle_cnt == IDLE_MAX);

   always_comb begin
      case (state)
         S_K1:    exp_nib = KEY[11:8];
         S_K2:    exp_nib = KEY[7:4];
         S_K3:    exp_nib = KEY[3:0];
         default: exp_nib = KEY[15:12];
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= S_LOCKED;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      fail_ev   = 1'b0;
      key_done  = 1'b0;
      data_hit  = 1'b0;
      abort     = 1'b0;
      case (state)
         S_LOCKED: begin
            if (hit) begin
               if (nib == KEY[15:12]) state_nxt = S_K1;
               else                   fail_ev   = 1'b1;
            end
         end
         S_K1, S_K2, S_K3: begin
            if (wwr) begin
               state_nxt = S_LOCKED;
               abort     = 1'b1;
            end else if (hit) begin
               if (nib == exp_nib) begin
                  case (state)
                     S_K1:    state_nxt = S_K2;
                     S_K2:    state_nxt = S_K3;
                     default: state_nxt = S_UNLOCKED;
                  endcase
                  key_done = (state == S_K3);
               end else begin
                  fail_ev   = 1'b1;
                  state_nxt = (nib == KEY[15:12]) ? S_K1 : S_LOCKED;
               end
            end else if (timed_out) begin
               state_nxt = S_LOCKED;
               abort     = 1'b1;
            end
         end
         S_UNLOCKED: begin
            if (wwr) begin
               state_nxt = S_LOCKED;
               abort     = 1'b1;
            end else if (hit) begin
               data_hit = 1'b1;
               if (bit_cnt == 5'd31) begin
                  state_nxt = S_LOCKED;
                  abort     = 1'b1;
               end
            end else if (timed_out) begin
               state_nxt = S_LOCKED;
               abort     = 1'b1;
            end
         end
         S_LOCKOUT: begin
            if (lock_cnt == '0) state_nxt = S_LOCKED;
         end
         default: state_nxt = S_LOCKED;
      endcase
      // a third failure overrides whatever the mismatching hit would have done
      if (fail_ev && fail_trip) state_nxt = S_LOCKOUT;
   end

   always_comb begin
      unlocked   = (state == S_UNLOCKED);
      locked_out = (state == S_LOCKOUT);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fail_cnt <= '0;
         idle_cnt <= '0;
         lock_cnt <= '0;
         bit_cnt  <= '0;
         sdrd     <= 1'b0;
         sdrd_oe  <= 1'b0;
      end else begin
         if (fail_ev)       fail_cnt <= fail_trip ? 2'd0 : fail_sat;
         else if (key_done) fail_cnt <= 2'd0;

         if (fail_ev && fail_trip)                    lock_cnt <= LOCK_MAX;
         else if (state == S_LOCKOUT && lock_cnt != '0) lock_cnt <= lock_cnt - 1'b1;

         if (active && !hit && !abort) idle_cnt <= idle_cnt + 1'b1;
         else                          idle_cnt <= '0;

         if (abort)         bit_cnt <= '0;
         else if (data_hit) bit_cnt <= bit_cnt + 5'd1;

         sdrd    <= data_hit & ID[bit_cnt];
         sdrd_oe <= data_hit;
      end
   end

endmodule
